// File: rtl/rsa_pkg.sv
// Shared constants and state types for the modular-exponentiation engine.
package rsa_pkg;
  localparam int WIDTH = 8;
  localparam int ACC_W = WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int BIT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TOM  = 3'd1,
    TOX  = 3'd2,
    SQR  = 3'd3,
    MUL  = 3'd4,
    FROM = 3'd5,
    DONE = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_ITER = 2'd1,
    MM_FIX  = 2'd2
  } mm_phase_t;
endpackage

// File: rtl/rsa_montmul.sv
// Bit-serial Montgomery multiplier: res = a*b*2^-WIDTH mod p in WIDTH+2 cycles
// counting the issue cycle in which go is high.
module rsa_montmul
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] res,
  output logic             rdy
);
  mm_phase_t        phase;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] p_r;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] p_ext;

  always_comb begin
    p_ext = {2'b00, p_r};
    sum   = acc;
    if (a_sh[0]) begin
      sum = sum + {2'b00, b_r};
    end else begin
      sum = sum;
    end
    // Adding the odd modulus makes the sum even so the shift is exact.
    if (sum[0]) begin
      sum = sum + p_ext;
    end else begin
      sum = sum;
    end
    acc_nxt = {1'b0, sum[ACC_W-1:1]};
    if (acc >= p_ext) begin
      res = WIDTH'(acc - p_ext);
    end else begin
      res = acc[WIDTH-1:0];
    end
    rdy = (phase == MM_FIX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= MM_IDLE;
      a_sh  <= '0;
      b_r   <= '0;
      p_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (phase)
        MM_IDLE: begin
          if (go) begin
            a_sh  <= a;
            b_r   <= b;
            p_r   <= p;
            acc   <= '0;
            cnt   <= '0;
            phase <= MM_ITER;
          end
        end
        MM_ITER: begin
          acc  <= acc_nxt;
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            phase <= MM_FIX;
          end
        end
        MM_FIX:  phase <= MM_IDLE;
        default: phase <= MM_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation, c = m^e mod p,
// sequencing one shared Montgomery multiplier.
module rsa_modexp
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] r2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c
);
  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] p_r, e_r, m_r, r2_r, x_r, xm_r;
  logic [BIT_W-1:0] bit_idx;
  logic             run;
  logic             go;
  logic             bit_dec;
  logic             accept;
  logic [WIDTH-1:0] op_a, op_b, mm_res;
  logic             mm_rdy;

  rsa_montmul u_mm (
    .clk (clk),
    .rst (rst),
    .go  (go),
    .a   (op_a),
    .b   (op_b),
    .p   (p_r),
    .res (mm_res),
    .rdy (mm_rdy)
  );

  always_comb begin
    op_a      = '0;
    op_b      = '0;
    state_nxt = state;
    bit_dec   = 1'b0;
    // done gates acceptance so a start in the pulse cycle is dropped.
    accept    = (state == IDLE) && start && !done;
    go        = !run && (state != IDLE) && (state != DONE);
    case (state)
      IDLE: begin
        if (accept) state_nxt = TOM;
        else        state_nxt = IDLE;
      end
      TOM: begin
        op_a = m_r;
        op_b = r2_r;
        if (mm_rdy) state_nxt = TOX;
        else        state_nxt = TOM;
      end
      TOX: begin
        op_a = WIDTH'(1);
        op_b = r2_r;
        if (mm_rdy) state_nxt = SQR;
        else        state_nxt = TOX;
      end
      SQR: begin
        op_a = x_r;
        op_b = x_r;
        if (mm_rdy) begin
          if (e_r[bit_idx])              state_nxt = MUL;
          else if (bit_idx == BIT_W'(0)) state_nxt = FROM;
          else begin
            state_nxt = SQR;
            bit_dec   = 1'b1;
          end
        end else begin
          state_nxt = SQR;
        end
      end
      MUL: begin
        op_a = x_r;
        op_b = xm_r;
        if (mm_rdy) begin
          if (bit_idx == BIT_W'(0)) state_nxt = FROM;
          else begin
            state_nxt = SQR;
            bit_dec   = 1'b1;
          end
        end else begin
          state_nxt = MUL;
        end
      end
      FROM: begin
        op_a = x_r;
        op_b = WIDTH'(1);
        if (mm_rdy) state_nxt = DONE;
        else        state_nxt = FROM;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      p_r     <= '0;
      e_r     <= '0;
      m_r     <= '0;
      r2_r    <= '0;
      x_r     <= '0;
      xm_r    <= '0;
      bit_idx <= '0;
      run     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      c       <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state != IDLE) && (state != DONE);
      done  <= (state == DONE);
      if (accept) begin
        p_r     <= p;
        e_r     <= e;
        m_r     <= m;
        r2_r    <= r2;
        bit_idx <= BIT_W'(WIDTH - 1);
      end else if (bit_dec) begin
        bit_idx <= bit_idx - BIT_W'(1);
      end
      if (go)          run <= 1'b1;
      else if (mm_rdy) run <= 1'b0;
      // Product results land in their destination during the fix cycle.
      if (mm_rdy) begin
        case (state)
          TOM:            xm_r <= mm_res;
          TOX, SQR, MUL:  x_r  <= mm_res;
          FROM:           c    <= mm_res;
          default:        x_r  <= x_r;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp: directed vector table, mid-run disturbance,
// reset corner cases and a randomized sweep against a plain pow(m,e,p) model.
module tb_rsa_modexp;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] p = 8'd0, e = 8'd0, m = 8'd0, r2 = 8'd0;
  logic       busy, done;
  logic [7:0] c;
  int         n_pass = 0;
  int         n_total = 0;

  rsa_modexp dut (
    .clk (clk), .rst (rst), .start (start), .p (p), .e (e), .m (m), .r2 (r2),
    .busy (busy), .done (done), .c (c)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pv; int ev; int mv; int r2v; int cexp;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic int ref_pow(input int mv, input int ev, input int pv);
    longint r = 1;
    longint b = mv % pv;
    for (int i = 7; i >= 0; i--) begin
      r = (r * r) % pv;
      if ((ev >> i) & 1) r = (r * b) % pv;
    end
    return int'(r % pv);
  endfunction

  function automatic int ones(input int v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += (v >> i) & 1;
    return n;
  endfunction

  // mode 0: plain run; 1: second start and input changes mid-run; 2: reset at cycle 50
  task automatic run(input int pv, input int ev, input int mv, input int r2v,
                     input int cexp, input int mode);
    int lat_exp, cnt, busy_cnt, both, extra;
    bit got;
    lat_exp = (3 + 8 + ones(ev)) * 10 + 1;
    @(negedge clk);
    p = 8'(pv); e = 8'(ev); m = 8'(mv); r2 = 8'(r2v); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0; busy_cnt = 0; both = 0; got = 1'b0;
    while (!got && cnt < 2000) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && done) both++;
      if (done) got = 1'b1;
      else begin
        if (mode == 1 && cnt == 30) begin
          start = 1'b1; p = 8'd251; e = 8'd255; m = 8'd3; r2 = 8'd17;
        end
        if (mode == 1 && cnt == 31) start = 1'b0;
        if (mode == 2 && cnt == 50) begin
          rst = 1'b1;
          @(posedge clk);
          #1 rst = 1'b0;
          @(negedge clk);
          check("rst_busy", int'(busy), 0);
          check("rst_done", int'(done), 0);
          check("rst_c", int'(c), 0);
          return;
        end
        cnt++;
      end
    end
    check("done_seen", int'(got), 1);
    check("result_c", int'(c), cexp);
    check("latency", cnt, lat_exp);
    check("busy_cycles", busy_cnt, lat_exp - 1);
    check("busy_done_overlap", both, 0);
    @(negedge clk);
    check("done_pulse_width", int'(done), 0);
    if (mode == 1) begin
      extra = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("ignored_start", extra, 0);
    end
  endtask

  initial begin
    vec_t vecs[5];
    int pv, mv, ev, r2v;
    vecs[0] = '{143, 7,   9,   42, 48};
    vecs[1] = '{143, 103, 48,  42, 9};
    vecs[2] = '{143, 1,   200, 42, 57};
    vecs[3] = '{143, 0,   77,  42, 1};
    vecs[4] = '{143, 5,   0,   42, 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_c", int'(c), 0);

    foreach (vecs[i]) run(vecs[i].pv, vecs[i].ev, vecs[i].mv, vecs[i].r2v, vecs[i].cexp, 0);

    run(143, 7, 9, 42, 48, 1);
    run(143, 7, 9, 42, 48, 2);
    run(143, 7, 9, 42, 48, 0);

    // start coincident with rst must not launch a run
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("start_with_rst", int'(busy), 0);

    for (int k = 0; k < 10; k++) begin
      pv  = 2 * int'($urandom_range(1, 127)) + 1;
      mv  = int'($urandom_range(0, 255));
      ev  = int'($urandom_range(0, 255));
      r2v = (256 * 256) % pv;
      run(pv, ev, mv, r2v, ref_pow(mv, ev, pv), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
